// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder
//   Slave end of the core's dmem_* interface. A request is taken in the
//   address phase; in the following data phase a load returns the whole
//   aligned word and a store commits its byte lanes at the end of the final
//   data-phase cycle. WAIT_CYCLES wait states are inserted per transfer, and
//   out-of-range, misaligned or illegally sized accesses are flagged on
//   dmem_badmem_e instead of touching memory.
//
// Ports
//   clk                 rising-edge clock
//   reset_n             synchronous active-low reset
//   dmem_en             request valid (address phase)
//   dmem_wen            1 = store, 0 = load
//   dmem_size           0 byte, 1 half, 2 word, others illegal
//   dmem_addr           byte address (address phase)
//   dmem_wdata_delayed  lane-replicated store data (data phase)
//   dmem_wait           data phase not yet complete
//   dmem_rdata          aligned read word, held outside the final cycle
//   dmem_badmem_e       access error, valid in the final cycle
module rv32i_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic        dmem_wait,
  output logic [31:0] dmem_rdata,
  output logic        dmem_badmem_e
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FINAL} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [3:0] lane_strobe(input logic [2:0] size,
                                             input logic [1:0] ofs,
                                             input logic       err);
    logic [3:0] s;
    case (size)
      3'd0:    s = 4'b0001 << ofs;
      3'd1:    s = 4'b0011 << ofs;
      default: s = 4'b1111;
    endcase
    return err ? 4'b0000 : s;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

  // ---- p0: address-phase decode ----
  logic [31:0]   off_p0;
  logic          err_p0;
  logic [AW-1:0] idx_p0;
  logic [3:0]    strb_p0;
  logic          accept;

  // BASE_ADDR is aligned to the memory span, so the offset's low bits equal
  // the address's low bits and can be used for the alignment checks.
  assign off_p0  = dmem_addr - BASE_ADDR;
  assign err_p0  = (off_p0 >= SPAN) || (dmem_size > 3'd2) ||
                   (dmem_size == 3'd1 && off_p0[0]) ||
                   (dmem_size == 3'd2 && off_p0[1:0] != 2'b00);
  assign idx_p0  = off_p0[AW+1:2];
  assign strb_p0 = lane_strobe(dmem_size, off_p0[1:0], err_p0);
  assign accept  = dmem_en && (state != S_WAIT);

  // ---- p1: registered request, owned by the transfer in WAIT/FINAL ----
  logic [AW-1:0] idx_p1;
  logic [3:0]    strb_p1;
  logic          wen_p1;
  logic          err_p1;

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p1  <= idx_p0;
      strb_p1 <= strb_p0;
      wen_p1  <= dmem_wen;
      err_p1  <= err_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_FINAL;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: begin
        // IDLE and FINAL both accept, so back-to-back transfers overlap the
        // final cycle of one with the address phase of the next.
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_FINAL;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  assign dmem_wait     = (state == S_WAIT);
  assign dmem_badmem_e = (state == S_FINAL) && err_p1;

  // ---- p2: memory access (store commit and load capture) ----
  // The transfer entering FINAL comes straight from the address phase unless
  // it has been waiting, in which case its registered copy is used.
  logic          from_p0;
  logic [AW-1:0] rd_idx;
  logic          rd_zero;
  logic          wr_en;
  logic [3:0]    byp_strb;

  assign from_p0  = (state != S_WAIT);
  assign rd_idx   = from_p0 ? idx_p0 : idx_p1;
  assign rd_zero  = from_p0 ? (err_p0 || dmem_wen) : (err_p1 || wen_p1);
  assign wr_en    = reset_n && (state == S_FINAL) && wen_p1 && !err_p1;
  // A store committing on the same edge to the same word is merged in, since
  // the array read still returns the pre-write contents.
  assign byp_strb = (wr_en && idx_p1 == rd_idx) ? strb_p1 : 4'b0000;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (strb_p1[b]) mem[idx_p1][8*b +: 8] <= dmem_wdata_delayed[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dmem_rdata <= 32'd0;
    end else if (state_nxt == S_FINAL) begin
      dmem_rdata <= rd_zero ? 32'd0
                            : merge_lanes(mem[rd_idx], dmem_wdata_delayed, byp_strb);
    end
  end

endmodule

// File: doc/rv32i_dmem_responder.md
# rv32i_dmem_responder

Single-port data-memory responder forming the slave end of the core's `dmem_*` interface. It accepts address-phase requests, then, in the following data phase, returns the aligned read word or commits the delayed store data under byte strobes. It inserts a configurable number of wait states and flags out-of-range or misaligned accesses on `dmem_badmem_e`. It sits beside the pipeline in the platform top, in place of a behavioural memory model, and is synthesisable to block RAM.

## Interface
- `DEPTH_WORDS`, 4096: number of 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_CYCLES`, 0: wait states per transfer, legal range 0..15.
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `dmem_en` in 1: request valid in address phase.
- `dmem_wen` in 1: 1 = store, 0 = load.
- `dmem_size` in `MEM_TYPE_WIDTH` (3): 0 = byte, 1 = half, 2 = word; any other value is illegal.
- `dmem_addr` in `XPR_LEN` (32): byte address, address phase.
- `dmem_wdata_delayed` in `XPR_LEN`: store data, lane-replicated by the core, valid in the data phase.
- `dmem_wait` out 1: data phase not complete; the core holds its pipeline.
- `dmem_rdata` out `XPR_LEN`: full aligned word; the core extracts bytes/halves.
- `dmem_badmem_e` out 1: access error, valid in the final data-phase cycle.

## Operation
- **Address phase (accept).** A request is accepted on any edge where `dmem_en=1` and `dmem_wait=0`. On acceptance, register `addr[31:2]`, `addr[1:0]`, `wen` and `size`. While `dmem_wait=1`, new requests are ignored; the core keeps them stable.
- **Error detection.**
  - `off = dmem_addr - BASE_ADDR`.
  - Out of range: `off >= DEPTH_WORDS*4`.
  - Misaligned: half with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - Illegal size: `size > 2`.
  - Error is registered at acceptance.
- **Byte strobes.**
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << addr[1:0]`.
  - Word: `4'b1111`.
  - On error: `4'b0000`.
- **FSM states:**
  - IDLE: no transfer outstanding.
  - WAIT: count down from `WAIT_CYCLES`.
  - FINAL: the data-phase completion cycle.
- **FSM transitions:**
  - Accept with `WAIT_CYCLES=0`: go to FINAL.
  - Accept with `WAIT_CYCLES>0`: go to WAIT with `cnt=WAIT_CYCLES-1`.
  - WAIT with `cnt=0`: go to FINAL; otherwise `cnt--`.
  - FINAL with a new accept in the same cycle: go to FINAL (or WAIT), so back-to-back transfers pipeline.
  - FINAL with no accept: go to IDLE.
- **Wait output.** `dmem_wait=1` exactly while in WAIT.
- **Store commit.** In FINAL with `wen=1`: write `dmem_wdata_delayed` lanes selected by the strobes into the registered word, at the end of the cycle. Nothing is written on error.
- **Load data.** `dmem_rdata` is a register loaded on the edge that enters FINAL with the addressed word, or 0 on error or store. It holds its value outside FINAL.
- **Read-after-write bypass.** If a store commits on that same edge to the same word, merge its strobed bytes into the loaded value. A load immediately after a store to the same word returns the new data.
- **Error output.** `dmem_badmem_e` is high only in FINAL of an erroneous transfer.
- **Reset.** `reset_n=0` mid-transfer aborts it: any pending store is dropped and the state returns to IDLE. Memory contents are not cleared.

## Timing
- Reset values: `dmem_wait=0`, `dmem_rdata=0`, `dmem_badmem_e=0`, state IDLE, `cnt=0`.
- Load latency: accept at edge N, data valid in cycle N+1+`WAIT_CYCLES`.
- Store latency: data sampled in the same cycle as load data, committed at its closing edge.
- Throughput: one transfer per `WAIT_CYCLES+1` cycles; with `WAIT_CYCLES=0`, one transfer per cycle.
- `dmem_wait` rises the cycle after acceptance and falls on entry to FINAL. It never asserts when `WAIT_CYCLES=0`.
- `dmem_en=0` in FINAL → IDLE the next cycle; no spurious write.
- Address wrap: the index is `off[log2(DEPTH_WORDS*4)-1:2]`. Out-of-range addresses never alias; they are reported as errors.
- `reset_n` deasserted and `dmem_en=1` in the same cycle: accepted on that edge.

## Test plan
- **Word round-trip, WAIT=0.** SW 32'hDEADBEEF @0x10, then LW @0x10 back-to-back → `dmem_rdata=32'hDEADBEEF` one cycle after the load is accepted (bypass path); `dmem_wait` stays 0.
- **Byte/half strobes.** Word @0x20 = 32'h11223344; SB 0xAA (replicated) @0x21; SH 0xBBBB @0x22 → LW @0x20 = 32'hBBBBAA44.
- **Wait states, WAIT_CYCLES=3.** LW accepted at edge N → `dmem_wait` high in cycles N+1..N+3, data in N+4. The request held stable during the wait is accepted at edge N+4.
- **Errors.**
  - LW @0x2 → `dmem_badmem_e=1`, `rdata=0`.
  - SW @`DEPTH_WORDS*4` → `badmem_e=1`, no word modified.
  - `size=3` → `badmem_e=1`.
- **Reset mid-transfer.** WAIT_CYCLES=2, SW 32'h12345678 @0x0 (old value 0), `reset_n=0` during WAIT → outputs return to reset values; later LW @0x0 returns 0.
